// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and operand-signedness helpers
// shared by the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step
// (shift in a dividend bit, subtract divisor if it fits).
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    // Remainder stays below the divisor, so the top bit is always dropped.
    assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with register-file write-back.
// Optional MULDIV_FASTPATH_EN retires trivial/special cases straight to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    muldiv_state_e state, state_nxt;
    muldiv_op_e    op_in, op_q;

    logic [4:0]        rd_q;
    logic              sa_q, sb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] prod_q;

    logic            accept;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            fast_hit;
    logic [XLEN-1:0] fast_data;

    assign op_in  = muldiv_op_e'(op);
    assign accept = (state == IDLE) & start & ~flush;

    assign sa_in = is_signed_a(op_in) & rs1_data[XLEN-1];
    assign sb_in = is_signed_b(op_in) & rs2_data[XLEN-1];
    assign abs_a = sa_in ? (~rs1_data + 1'b1) : rs1_data;
    assign abs_b = sb_in ? (~rs2_data + 1'b1) : rs2_data;

    logic div_zero, div_ovf, mul_zero;

    always_comb begin
        div_zero  = 1'b0;
        div_ovf   = 1'b0;
        mul_zero  = 1'b0;
        fast_hit  = 1'b0;
        fast_data = '0;
`ifdef MULDIV_FASTPATH_EN
        div_zero = is_div(op_in) & (rs2_data == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM})
                 & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                 & (&rs2_data);
        mul_zero = ~is_div(op_in)
                 & ((rs1_data == '0) | (rs2_data == '0));
        fast_hit = div_zero | div_ovf | mul_zero;
        if (div_zero)
            fast_data = is_rem(op_in) ? rs1_data : '1;
        else if (div_ovf)
            fast_data = is_rem(op_in) ? '0 : rs1_data;
`endif
    end

    // Iteration datapath: shift-add multiply, restoring divide.
    logic [XLEN:0]     add_sum;
    logic [XLEN-1:0]   rem_next;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    assign add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]}
                   + {1'b0, opnd_q & {XLEN{prod_q[0]}}};
    assign mul_nxt = {add_sum, prod_q[XLEN-1:1]};

    muldiv_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem      (prod_q[2*XLEN-1:XLEN]),
        .dvd_bit  (prod_q[XLEN-1]),
        .divisor  (opnd_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign div_nxt = {rem_next, prod_q[XLEN-2:0], q_bit};

    // Sign fix-up and result selection.
    logic [2*XLEN-1:0] mul_res;
    logic [XLEN-1:0]   quo, rem, q_res, r_res, fix_data;

    assign quo     = prod_q[XLEN-1:0];
    assign rem     = prod_q[2*XLEN-1:XLEN];
    assign mul_res = (sa_q ^ sb_q) ? -prod_q : prod_q;
    assign r_res   = sa_q ? -rem : rem;
    assign q_res   = (opnd_q == '0) ? '1
                   : ((sa_q ^ sb_q) ? -quo : quo);

    always_comb begin
        fix_data = '0;
        unique case (1'b1)
            op_q == OP_MUL:
                fix_data = mul_res[XLEN-1:0];
            op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}:
                fix_data = mul_res[2*XLEN-1:XLEN];
            op_q inside {OP_DIV, OP_DIVU}:
                fix_data = q_res;
            op_q inside {OP_REM, OP_REMU}:
                fix_data = r_res;
            default:
                fix_data = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)
                state_nxt = fast_hit ? DONE : CALC;
            CALC: if (flush)
                state_nxt = IDLE;
            else if (cnt_q == CNT_W'(1))
                state_nxt = FIX;
            FIX:
                state_nxt = flush ? IDLE : DONE;
            DONE:
                state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q    <= OP_MUL;
            rd_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q  <= op_in;
                    rd_q  <= rd_in;
                    sa_q  <= sa_in;
                    sb_q  <= sb_in;
                    cnt_q <= CNT_W'(XLEN);
                    if (is_div(op_in)) begin
                        opnd_q <= abs_b;
                        prod_q <= {{XLEN{1'b0}}, abs_a};
                    end else begin
                        opnd_q <= abs_a;
                        prod_q <= {{XLEN{1'b0}}, abs_b};
                    end
                    if (fast_hit) begin
                        wb_data <= fast_data;
                        wb_rd   <= rd_in;
                    end
                end
                CALC: begin
                    cnt_q  <= cnt_q - 1'b1;
                    prod_q <= is_div(op_q) ? div_nxt : mul_nxt;
                end
                FIX: if (!flush) begin
                    wb_data <= fix_data;
                    wb_rd   <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign stall_req = (start & (state == IDLE))
                     | (state == CALC)
                     | (state == FIX);

    // Write strobe drops on flush and never targets x0.
    assign wb_we = (state == DONE) & ~flush & (wb_rd != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random scoreboard bench for muldiv_unit.
module tb_muldiv_unit;

    localparam int XLEN = 32;

`ifdef MULDIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic [4:0]      rd;
    logic            flush;
    logic            stall_req;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    muldiv_unit #(
        .XLEN (XLEN)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .start     (start),
        .op        (op),
        .rs1_data  (a),
        .rs2_data  (b),
        .rd_in     (rd),
        .flush     (flush),
        .stall_req (stall_req),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy, uy, sp;
        logic [63:0]        up;
        logic signed [31:0] xs, ys, qs;
        logic [31:0]        r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        uy = {32'b0, y};
        up = {32'b0, x} * {32'b0, y};
        xs = x;
        ys = y;
        r  = '0;
        case (o)
            3'd0: r = up[31:0];
            3'd1: begin sp = sx * sy; r = sp[63:32]; end
            3'd2: begin sp = sx * uy; r = sp[63:32]; end
            3'd3: r = up[63:32];
            3'd4: begin
                if (y == 0) r = '1;
                else if (x == 32'h8000_0000 && y == '1) r = x;
                else begin qs = xs / ys; r = qs; end
            end
            3'd5: r = (y == 0) ? '1 : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == '1) r = '0;
                else begin qs = xs % ys; r = qs; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] o,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
        if (o >= 3'd4 && y == 0) return 1'b1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == '1)
            return 1'b1;
        if (o < 3'd4 && (x == 0 || y == 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one op; inject>0 pulses a stray start at that cycle.
    task automatic run(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [4:0] r,
                       input logic [31:0] exp_d,
                       input int inject);
        int   lat;
        int   stalls;
        int   exp_lat;
        bit   seen;
        exp_t e;
        exp_lat = (is_special(o, x, y) && FAST) ? 1 : XLEN + 2;
        @(negedge Clk);
        op = o; a = x; b = y; rd = r; start = 1'b1;
        #1 chk("stall_on_issue", stall_req, 1);
        if (r != 0) sbq.push_back('{r, exp_d});
        @(negedge Clk);
        start = 1'b0;
        lat = 1; stalls = 0; seen = 1'b0;
        while (lat <= XLEN + 6) begin
            if (wb_we) begin
                seen = 1'b1;
                break;
            end
            if (stall_req) stalls++;
            if (inject != 0 && lat == inject) begin
                start = 1'b1; op = 3'd0; rd = 5'd9;
                a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            lat++;
        end
        start = 1'b0;
        if (r != 0) begin
            chk("wb_seen", seen, 1);
            if (seen) begin
                chk("latency", lat, exp_lat);
                chk("stall_cycles", stalls, exp_lat - 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                end
            end
        end else begin
            chk("no_wb_for_x0", seen, 0);
            chk("stall_cycles_x0", stalls, exp_lat - 1);
        end
    endtask

    initial begin
        int cnt;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [4:0]  rr;

        Rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0; rd = '0;
        repeat (2) @(negedge Clk);
        chk("rst_stall", stall_req, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_data", wb_data, 0);
        Rst_n = 1'b1;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 0);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 0);
        run(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 32'hFFFF_FFFF, 0);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, 0);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 0);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 0);
        run(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 5);
        #1 chk("stray_start_ignored", stall_req, 0);
        run(3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 0);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 0);
        run(3'd5, 32'd7, 32'd0, 5'd15, 32'hFFFF_FFFF, 0);
        run(3'd7, 32'd7, 32'd0, 5'd16, 32'd7, 0);
        run(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFFF, 0);
        run(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFF9, 0);
        run(3'd0, 32'd0, 32'h1234, 5'd19, 32'h0, 0);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            rr = 5'($urandom_range(1, 31));
            run(ro, rx, ry, rr, ref_res(ro, rx, ry), 0);
        end

        // Flush in the tenth CALC cycle.
        @(negedge Clk);
        op = 3'd0; a = 32'd5; b = 32'd6; rd = 5'd7; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        flush = 1'b1;
        #1 chk("flush_we", wb_we, 0);
        @(negedge Clk);
        flush = 1'b0;
        #1 chk("flush_idle", stall_req, 0);
        cnt = 0;
        repeat (XLEN + 4) begin
            @(negedge Clk);
            if (wb_we) cnt++;
        end
        chk("flush_no_wb", cnt, 0);
        run(3'd5, 32'd1000, 32'd10, 5'd20, 32'd100, 0);

        // Asynchronous reset between edges mid-CALC.
        @(negedge Clk);
        op = 3'd0; a = 32'd9; b = 32'd9; rd = 5'd4; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (10) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_req, 0);
        chk("arst_we", wb_we, 0);
        chk("arst_rd", wb_rd, 0);
        chk("arst_data", wb_data, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        run(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 0);
        run(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
